// File: rtl/bram_result_writer.sv
// bram_result_writer: packs a stream of per-core result lanes into BRAM1 rows.
// Four RES_WIDTH lanes form one DWIDTH_2 row (lane 0 in the LSBs). A run of
// run_count_i rows is written to consecutive BRAM1 addresses starting at
// base_addr_i, wrapping at the top of the memory. Status flags mirror the
// BRAM0 read accessor so the controller can treat both sides alike.
module bram_result_writer #(
  parameter int CNT_BIT   = 31,
  parameter int DWIDTH_2  = 64,
  parameter int RES_WIDTH = 16,
  parameter int AWIDTH    = 8,
  parameter int MEM_SIZE  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_run_i,
  input  logic [CNT_BIT-1:0]   run_count_i,
  input  logic [AWIDTH-1:0]    base_addr_i,
  input  logic                 s_valid_i,
  input  logic [RES_WIDTH-1:0] s_data_i,
  output logic                 s_ready_o,
  output logic                 idle_o,
  output logic                 write_o,
  output logic                 done_o,
  output logic [AWIDTH-1:0]    addr_b1_o,
  output logic                 ce_b1_o,
  output logic                 we_b1_o,
  output logic [DWIDTH_2-1:0]  d_b1_o
);

  // Only lanes 0..2 need holding; lane 3 goes straight from the input into
  // the row written to BRAM1.
  localparam int PACK_W = DWIDTH_2 - RES_WIDTH;

  // Addresses wrap at the BRAM1 depth, which is a power of two.
  localparam logic [AWIDTH-1:0]  ADDR_MASK = AWIDTH'(MEM_SIZE - 1);
  localparam logic [CNT_BIT-1:0] CNT_ONE   = CNT_BIT'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [1:0]         lane_cnt;
  logic [CNT_BIT-1:0] row_cnt;
  logic [CNT_BIT-1:0] run_count_q;
  logic [AWIDTH-1:0]  base_q;
  logic [PACK_W-1:0]  pack_q;

  logic               start_accept;
  logic               lane_accept;
  logic               row_complete;
  logic               last_row;
  logic [AWIDTH-1:0]  row_addr;

  // Next-state logic plus the handshake events that drive the datapath.
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    lane_accept  = 1'b0;
    row_complete = 1'b0;
    last_row     = (row_cnt == (run_count_q - CNT_ONE));
    row_addr     = (base_q + row_cnt[AWIDTH-1:0]) & ADDR_MASK;
    case (state)
      IDLE: begin
        if (start_run_i) begin
          start_accept = 1'b1;
          state_next   = (run_count_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        lane_accept  = s_valid_i;
        row_complete = s_valid_i && (lane_cnt == 2'd3);
        if (row_complete && last_row) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status flags decoded from state; a DONE cycle counts as writing only when
  // it carries the final row's write pulse.
  always_comb begin
    idle_o    = 1'b0;
    s_ready_o = 1'b0;
    done_o    = 1'b0;
    write_o   = 1'b0;
    case (state)
      IDLE: idle_o = 1'b1;
      RUN: begin
        s_ready_o = 1'b1;
        write_o   = 1'b1;
      end
      DONE: begin
        done_o  = 1'b1;
        write_o = ce_b1_o;
      end
      default: idle_o = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Run parameters, lane/row counters and the partial-row pack register.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_count_q <= '0;
      base_q      <= '0;
      lane_cnt    <= '0;
      row_cnt     <= '0;
      pack_q      <= '0;
    end else if (start_accept) begin
      run_count_q <= run_count_i;
      base_q      <= base_addr_i;
      lane_cnt    <= '0;
      row_cnt     <= '0;
      pack_q      <= '0;
    end else if (lane_accept) begin
      lane_cnt <= lane_cnt + 2'd1;
      if (row_complete) begin
        row_cnt <= row_cnt + CNT_ONE;
        pack_q  <= '0;
      end else begin
        case (lane_cnt)
          2'd0:    pack_q[0 +: RES_WIDTH]           <= s_data_i;
          2'd1:    pack_q[RES_WIDTH +: RES_WIDTH]   <= s_data_i;
          2'd2:    pack_q[2*RES_WIDTH +: RES_WIDTH] <= s_data_i;
          default: pack_q <= pack_q;
        endcase
      end
    end
  end

  // BRAM1 port: a one-cycle write pulse per completed row, all-zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_b1_o   <= 1'b0;
      we_b1_o   <= 1'b0;
      addr_b1_o <= '0;
      d_b1_o    <= '0;
    end else if (row_complete) begin
      ce_b1_o   <= 1'b1;
      we_b1_o   <= 1'b1;
      addr_b1_o <= row_addr;
      d_b1_o    <= {s_data_i, pack_q};
    end else begin
      ce_b1_o   <= 1'b0;
      we_b1_o   <= 1'b0;
      addr_b1_o <= '0;
      d_b1_o    <= '0;
    end
  end

endmodule

// File: doc/bram_result_writer.md
Name: bram_result_writer

Overview:
- Write-side counterpart of the BRAM0 read accessor.
- Accepts a stream of per-core accumulation results, packs four lanes into one BRAM1 row, and writes `run_count_i` rows to BRAM1 starting at `base_addr_i`.
- Exposes idle/write/done status to the register/controller side, in the same style as the read accessor.

Parameters:
- CNT_BIT, 31, width of the row counter and `run_count_i`.
- DWIDTH_2, 64, BRAM1 data width; must equal 4*RES_WIDTH.
- RES_WIDTH, 16, width of one core result lane.
- AWIDTH, 8, BRAM1 address width.
- MEM_SIZE, 256, BRAM1 depth; must equal 2**AWIDTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_run_i  input  1  start pulse; sampled only in IDLE.
- run_count_i  input  CNT_BIT  number of rows to write; captured on accepted start.
- base_addr_i  input  AWIDTH  first BRAM1 row address; captured on accepted start.
- s_valid_i  input  1  result lane valid.
- s_data_i  input  RES_WIDTH  result lane data.
- s_ready_o  output  1  lane accepted when s_valid_i && s_ready_o at a rising edge.
- idle_o / write_o / done_o  output  1 each  state flags, decoded from state.
- addr_b1_o  output  AWIDTH  BRAM1 address, registered.
- ce_b1_o / we_b1_o  output  1 each  BRAM1 chip/write enable, registered, always equal.
- d_b1_o  output  DWIDTH_2  BRAM1 write data, registered.

Behaviour:
- Reset: clk/reset are one clock, synchronous active-high, as already decided.
- Reset values: state=IDLE, so idle_o=1, write_o=0, done_o=0, s_ready_o=0. Also ce_b1_o=we_b1_o=0, addr_b1_o=0, d_b1_o=0. Lane counter, row counter, pack register, captured count and base all 0.
- Reset asserted mid-run aborts immediately; no further BRAM1 writes are issued.
- States: IDLE, RUN, DONE.
- IDLE->RUN: start_run_i=1 and run_count_i!=0. run_count_i and base_addr_i are captured; lane and row counters are cleared.
- IDLE->DONE: start_run_i=1 and run_count_i==0. No writes occur; done_o is high for one cycle.
- RUN->DONE: on the edge that accepts lane 3 of row (count-1).
- DONE->IDLE: unconditionally after one cycle.
- start_run_i outside IDLE is ignored. It does not restart the run or recapture inputs.
- s_ready_o=1 only in RUN. There is no backpressure from BRAM1, so throughput is one lane per cycle.
- Packing: lane n (0..3) of a row goes to bits [n*RES_WIDTH +: RES_WIDTH]. Lane 0 is the LSB and is the first lane accepted.
- Lane counter is 2 bits and wraps 3->0 on acceptance of lane 3.
- Write pulse: acceptance of lane 3 at edge E gives one cycle beginning at E with:
  - ce_b1_o=we_b1_o=1;
  - d_b1_o = {lane3, lane2, lane1, lane0};
  - addr_b1_o = (base + row) mod 2**AWIDTH.
- The row counter increments at edge E.
- In every cycle without a write pulse: ce_b1_o=we_b1_o=0, addr_b1_o=0, d_b1_o=0.
- Back-to-back rows: consecutive write pulses are 4 cycles apart when s_valid_i stays high.
- Gaps in s_valid_i only stall lane acceptance. The partial pack register is held.
- The final row's write pulse coincides with the DONE cycle, i.e. ce_b1_o=1 and done_o=1 together.
- Address wrap: base=8'hFE with 3 rows writes addresses FE, FF, 00.
- write_o=1 in RUN, and also in DONE when that DONE cycle carries the final write pulse.
- Lanes presented in IDLE or DONE are not accepted.
- Lane counter arithmetic: 2-bit. Row counter arithmetic: CNT_BIT bits. The address adder truncates to AWIDTH.

Test Plan:
- Reset then idle → idle_o=1, ce_b1_o=0, s_ready_o=0 for 10 cycles; s_valid_i=1 is ignored.
- start, count=2, base=0x10; lanes 0x0001..0x0008 streamed continuously → expected writes:
  - addr 0x10 with d=0x0004_0003_0002_0001;
  - addr 0x11 with d=0x0008_0007_0006_0005, in the same cycle as done_o=1;
  - then idle_o=1.
- Same run with s_valid_i deasserted for 3 cycles between lanes 1 and 2 → identical data and addresses; the first write is delayed by exactly 3 cycles.
- base=0xFE, count=3 → writes at 0xFE, 0xFF, 0x00, with exactly 3 ce_b1_o pulses.
- count=0 start → one done_o cycle, zero ce_b1_o pulses, back to IDLE.
- Reset asserted after 6 lanes of a count=4 run → no further writes; outputs at reset values. A second start_run_i mid-run is ignored: count stays at the original value.
